// File: rtl/up_down_counter.sv
// -----------------------------------------------------------------------------
// up_down_counter
//
// Purpose:
//   WIDTH-bit unsigned up/down counter with a count enable.
//   The output comes straight from the count register.
//   The default build wraps at both ends of the range.
//
// Configuration macro:
//   UP_DOWN_COUNTER_SATURATE_EN
//     Undefined (default): counting wraps (max -> 0 going up, 0 -> max going down).
//     Defined: counting saturates (holds at max going up, holds at 0 going down).
//     The macro changes only the next-count arithmetic. The interface, reset
//     behaviour and one-cycle latency are the same in both builds.
//
// Parameters:
//   WIDTH    counter / output width in bits (>= 1)
//
// Ports:
//   clk      single clock; all state changes on its rising edge
//   reset    synchronous active-high reset; out -> 0, overrides counting
//   on       count enable: 1 = count, 0 = hold
//   up_down  direction: 1 = up, 0 = down (ignored while on = 0)
//   out      current count, registered
// -----------------------------------------------------------------------------
module up_down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             on,
   input  logic             up_down,
   output logic [WIDTH-1:0] out
);

   localparam logic [WIDTH-1:0] COUNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] COUNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1'b1);

   logic [WIDTH-1:0] count_r;
   logic [WIDTH-1:0] next_count_s;

   // Next value for one enabled or held cycle, excluding reset.
   // Arithmetic is unsigned and truncated to WIDTH bits.
   function automatic logic [WIDTH-1:0] count_step(
      input logic [WIDTH-1:0] cur,
      input logic             en,
      input logic             up
   );
      logic [WIDTH-1:0] nxt;
      case ({en, up})
         2'b11: begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
            if (cur == COUNT_MAX) begin
               nxt = COUNT_MAX;
            end else begin
               nxt = cur + COUNT_ONE;
            end
`else
            nxt = cur + COUNT_ONE;  // max + 1 truncates to 0
`endif
         end
         2'b10: begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
            if (cur == COUNT_ZERO) begin
               nxt = COUNT_ZERO;
            end else begin
               nxt = cur - COUNT_ONE;
            end
`else
            nxt = cur - COUNT_ONE;  // 0 - 1 truncates to max
`endif
         end
         default: begin
            nxt = cur;              // on = 0: hold regardless of direction
         end
      endcase
      return nxt;
   endfunction

   // Combinational next-count selection from the current register value.
   always_comb begin
      next_count_s = count_step(count_r, on, up_down);
   end

   // Count register. The synchronous reset has priority over counting and holding.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= COUNT_ZERO;
      end else begin
         count_r <= next_count_s;
      end
   end

   assign out = count_r;

endmodule

// File: tb/tb_up_down_counter.sv
// -----------------------------------------------------------------------------
// tb_up_down_counter
//
// Purpose:
//   Self-checking bench for up_down_counter with WIDTH = 4.
//   - When each step drives its inputs, a reference model computes the
//     expected count and pushes it onto a scoreboard queue.
//   - The expected value is popped and compared #1 after the rising edge.
//   - Constant checks pin the documented milestone values.
//   - Defining UP_DOWN_COUNTER_SATURATE_EN selects the saturating model
//     and the matching milestone constants.
// -----------------------------------------------------------------------------
module tb_up_down_counter;

   localparam int WIDTH = 4;

   logic             clk;
   logic             reset;
   logic             on;
   logic             up_down;
   logic [WIDTH-1:0] out;

   logic [WIDTH-1:0] model_q;
   logic [WIDTH-1:0] exp_q[$];
   int               n_checks;
   int               n_fail;

   up_down_counter #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .on      (on),
      .up_down (up_down),
      .out     (out)
   );

   // Free-running clock with a 10-time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model of one clock edge, written independently of the RTL.
   function automatic logic [WIDTH-1:0] model_next(
      input logic [WIDTH-1:0] cur,
      input logic             r,
      input logic             o,
      input logic             u
   );
      int v;
      v = int'(cur);
      if (r) begin
         v = 0;
      end else if (o && u) begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
         v = (v == 15) ? 15 : v + 1;
`else
         v = (v + 1) % 16;
`endif
      end else if (o) begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
         v = (v == 0) ? 0 : v - 1;
`else
         v = (v + 15) % 16;
`endif
      end
      return v[WIDTH-1:0];
   endfunction

   // Compare out against an expected value and count the result.
   task automatic check_val(input string tag, input logic [WIDTH-1:0] expv);
      n_checks++;
      assert (out === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, out, expv);
      end
   endtask

   // Pop the oldest expected value from the scoreboard and check it.
   task automatic check_pop(input string tag);
      logic [WIDTH-1:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL %s: observed %0d expected scoreboard entry (queue empty)", tag, out);
      end else begin
         e = exp_q.pop_front();
         check_val(tag, e);
      end
   endtask

   // Drive inputs away from the active edge and push the model result.
   // Then wait one edge and check out #1 after it.
   task automatic step(input logic r, input logic o, input logic u, input string tag);
      @(negedge clk);
      reset   = r;
      on      = o;
      up_down = u;
      model_q = model_next(model_q, r, o, u);
      exp_q.push_back(model_q);
      @(posedge clk);
      #1;
      check_pop(tag);
   endtask

   // Directed stimulus sequence.
   initial begin
      logic [WIDTH-1:0] held;
      n_checks = 0;
      n_fail   = 0;
      model_q  = 4'd0;
      reset    = 1'b1;
      on       = 1'b0;
      up_down  = 1'b0;

      // Two reset edges with on = 0.
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, "reset_hold");
      check_val("reset_value", 4'd0);

      // Ten up counts from zero.
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, "up_count");
      check_val("up_to_10", 4'd10);

      // Six more up counts: wrap to 0, or saturate at 15.
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, "up_wrap");
`ifdef UP_DOWN_COUNTER_SATURATE_EN
      check_val("up_sat_15", 4'd15);
`else
      check_val("up_wrap_0", 4'd0);
`endif

      // Direction change with no dead cycle: 15, 14, 13 after a wrap.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, "down_count");
`ifndef UP_DOWN_COUNTER_SATURATE_EN
      check_val("down_to_13", 4'd13);
`endif

      // Hold with on = 0 while up_down toggles; then resume counting.
      held = model_q;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, "hold");
         check_val("hold_const", held);
      end
      step(1'b0, 1'b1, 1'b1, "resume_up");
`ifndef UP_DOWN_COUNTER_SATURATE_EN
      check_val("resume_14", 4'd14);
`endif

      // Count down to 7, then reset mid-count with on = 1; reset wins.
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, "down_to_7");
`ifndef UP_DOWN_COUNTER_SATURATE_EN
      check_val("at_7", 4'd7);
`endif
      step(1'b1, 1'b1, 1'b1, "reset_mid_count");
      check_val("reset_mid_0", 4'd0);
      step(1'b0, 1'b1, 1'b1, "first_up_after_reset");
      check_val("first_up_1", 4'd1);

      // First down count after reset: 15 with wrap, 0 with saturation.
      step(1'b1, 1'b0, 1'b0, "reset_again");
      step(1'b0, 1'b1, 1'b0, "first_down_after_reset");
`ifdef UP_DOWN_COUNTER_SATURATE_EN
      check_val("first_down_sat_0", 4'd0);
`else
      check_val("first_down_15", 4'd15);
`endif

      // Reset asserted between edges must not change out until the next edge.
      step(1'b0, 1'b1, 1'b1, "pre_async_probe");
      held = model_q;
      @(negedge clk);
      reset = 1'b1;
      on    = 1'b0;
      #2;
      check_val("reset_between_edges", held);
      model_q = model_next(model_q, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(model_q);
      @(posedge clk);
      #1;
      check_pop("reset_at_edge");

      // Boundary run from zero: 18 up counts, then 18 down counts.
      for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 1'b1, "boundary_up");
`ifdef UP_DOWN_COUNTER_SATURATE_EN
      check_val("boundary_up_sat", 4'd15);
`else
      check_val("boundary_up_wrap", 4'd2);
`endif
      for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 1'b0, "boundary_down");
      check_val("boundary_down_0", 4'd0);

      // Every scoreboard entry should have been consumed.
      n_checks++;
      assert (exp_q.size() == 0)
      else begin
         n_fail++;
         $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
